cfa_window_seq: RTL and testbench
=================================

# cfa_window_seq

Sequencer for the multi-channel line-buffer datapath. It scans a frame held in sample memory one vertical strip of FILTER_SIZE rows at a time. For each sample it issues a read address to memory and times the buffer write-enable so the read data lands in the line buffer. When a complete FILTER_SIZE x FILTER_SIZE window is resident, it presents that window to the downstream filter engine through a valid/ready handshake. It sits between frame memory, the line buffer, and the CFA filter stage.

## Interface
- FILTER_SIZE, 5, window edge; must match the line buffer; must be ≥2.
- IMG_WIDTH, 64, frame columns; must be ≥ FILTER_SIZE.
- IMG_HEIGHT, 64, frame rows; must be ≥ FILTER_SIZE.
- RD_LAT, 1, fixed memory read latency in cycles; must be ≥1.
- ADDR_W, 12, memory address width; must be ≥ clog2(IMG_WIDTH*IMG_HEIGHT).
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- start  in  1  one-cycle frame start; ignored unless IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last window is accepted.
- mem_rd_en  out  1  read strobe; one address per cycle.
- mem_addr  out  ADDR_W  row-major sample address.
- buf_en  out  1  line-buffer write enable; equals mem_rd_en delayed RD_LAT cycles.
- buf_clr  out  1  line-buffer reset: combinational OR of rst and (state == CLEAR).
- win_valid  out  1  complete window resident in the buffer.
- win_ready  in  1  downstream accepts the window.
- win_row  out  clog2(IMG_HEIGHT)  top row of the presented window.
- win_col  out  clog2(IMG_WIDTH)  right-most column of the presented window.

## Operation
- FSM states and transitions:
  - IDLE: on start, set row_base=0 → CLEAR.
  - CLEAR (1 cycle): pulse buf_clr; set col=0, loaded=0, k=0 → FETCH.
  - FETCH (FILTER_SIZE cycles): mem_rd_en=1, mem_addr=(row_base+k)*IMG_WIDTH+col, k increments from 0 to FILTER_SIZE-1 → WAIT.
  - WAIT (RD_LAT cycles): lets in-flight reads retire; loaded saturates at FILTER_SIZE. Then → EMIT if loaded==FILTER_SIZE, else col++ → FETCH.
  - EMIT: win_valid=1, holding win_row=row_base and win_col=col. On win_ready:
    - col<IMG_WIDTH-1 → col++ → FETCH.
    - else row_base<IMG_HEIGHT-FILTER_SIZE → row_base++ → CLEAR.
    - else → DONE.
  - DONE (1 cycle): done=1 → IDLE.
- Each column fetch writes FILTER_SIZE samples, one per buffer line, top to bottom. This matches the buffer's one-hot line rotation, which the CLEAR pulse realigns at every strip.
- Address arithmetic is unsigned, computed at ADDR_W bits, with no wrap inside a legal frame.
- Per frame: windows = (IMG_WIDTH-FILTER_SIZE+1)*(IMG_HEIGHT-FILTER_SIZE+1); reads = IMG_WIDTH*FILTER_SIZE*(IMG_HEIGHT-FILTER_SIZE+1).
- The controller never issues buf_en while win_valid is high, so a presented window is stable until accepted.

## Timing
- Reset values: state=IDLE; busy, done, mem_rd_en, buf_en, win_valid = 0; mem_addr, win_row, win_col = 0; RD_LAT delay line cleared; buf_clr=1 while rst is high.
- First win_valid is high 2+FILTER_SIZE*(FILTER_SIZE+RD_LAT) cycles after the edge that samples start.
- After each window accept, the next window follows in FILTER_SIZE+RD_LAT+1 cycles within a strip, or +1 more cycle across strips (CLEAR).
- win_ready held high: no extra cycles. win_ready low: EMIT holds indefinitely and all outputs are frozen.
- start while busy: ignored. start coincident with rst: rst wins.
- rst mid-frame: next cycle is IDLE, with outputs at reset values and pending buf_en pulses discarded.

## Configuration
- CFA_WIN_SEQ_STALL_CNT_EN defined:
  - Adds output stall_cnt, 16 bits.
  - Counts cycles with win_valid && !win_ready, saturating at 0xFFFF.
  - Cleared by rst and on start accept.
- Undefined: the port and the counter are absent. All other behaviour is identical.

## Structure
- Shared package cfa_pkg holds:
  - FSM state enum (IDLE, CLEAR, FETCH, WAIT, EMIT, DONE).
  - clog2 helper.
  - Default FILTER_SIZE/RD_LAT constants shared with the line buffer.
- One sub-module, cfa_win_seq_addr_gen: row/k/col counters and the mem_addr multiply-add, registered output.

## Test plan
- FILTER_SIZE=3, IMG_WIDTH=8, IMG_HEIGHT=6, RD_LAT=1, win_ready=1, start → exactly 24 window accepts, 96 mem_rd_en cycles, first win_valid 14 cycles after start, single done pulse.
- Same config, address check → first 9 reads: 0,8,16,1,9,17,2,10,18. First window reports win_row=0, win_col=2.
- Backpressure: win_ready low 20 cycles at the third window → win_valid/win_row/win_col/mem_addr frozen, zero buf_en; resumes with no lost window.
- Strip boundary → after window (row 0, col 7) is accepted, buf_clr pulses once; next read addr=8 (row 1, col 0).
- rst asserted during FETCH of strip 2 → next cycle busy=0, mem_rd_en=0, buf_en=0. A new start replays the frame from addr 0.
- RD_LAT=3 → buf_en trails mem_rd_en by exactly 3 cycles. With CFA_WIN_SEQ_STALL_CNT_EN and 20 stall cycles, stall_cnt=20.

Source files
------------

// File: rtl/cfa_pkg.sv
// Shared definitions for the CFA window sequencer and the line buffer it feeds:
// FSM state encoding, a constant-safe clog2 helper and default geometry.
package cfa_pkg;

    // Defaults shared with the line buffer; both sides must agree on them.
    localparam int CFA_FILTER_SIZE = 5;
    localparam int CFA_RD_LAT      = 1;

    // Sequencer FSM states.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FETCH = 3'd2,
        WAIT  = 3'd3,
        EMIT  = 3'd4,
        DONE  = 3'd5
    } cfa_state_e;

    // Number of bits needed to index 'value' distinct items (value >= 2).
    function automatic int clog2(input int value);
        int v;
        int r;
        v = value - 1;
        r = 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/cfa_win_seq_addr_gen.sv
// Row/column/line counters of the window sequencer and the row-major
// sample address they imply. The address is registered from the next-state
// counter values, so it is valid in the same cycle the FSM is in FETCH.
module cfa_win_seq_addr_gen
    import cfa_pkg::*;
#(
    parameter int FILTER_SIZE = CFA_FILTER_SIZE,
    parameter int IMG_WIDTH   = 64,
    parameter int IMG_HEIGHT  = 64,
    parameter int ADDR_W      = 12
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          row_clr_i,
    input  logic                          row_inc_i,
    input  logic                          col_clr_i,
    input  logic                          col_inc_i,
    input  logic                          k_run_i,
    output logic [clog2(IMG_HEIGHT)-1:0]  row_o,
    output logic [clog2(IMG_WIDTH)-1:0]   col_o,
    output logic                          k_last_o,
    output logic                          col_last_o,
    output logic                          row_last_o,
    output logic [ADDR_W-1:0]             mem_addr_o
);

    localparam int RW = clog2(IMG_HEIGHT);
    localparam int CW = clog2(IMG_WIDTH);
    localparam int KW = clog2(FILTER_SIZE);

    logic [RW-1:0]     row_q, row_d;
    logic [CW-1:0]     col_q, col_d;
    logic [KW-1:0]     k_q, k_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    assign k_last_o   = (k_q == KW'(FILTER_SIZE - 1));
    assign col_last_o = (col_q == CW'(IMG_WIDTH - 1));
    assign row_last_o = (row_q == RW'(IMG_HEIGHT - FILTER_SIZE));
    assign row_o      = row_q;
    assign col_o      = col_q;
    assign mem_addr_o = addr_q;

    // Next counter values; k walks the strip lines only while fetching.
    always_comb begin
        row_d = row_q;
        if (row_clr_i)      row_d = '0;
        else if (row_inc_i) row_d = row_q + RW'(1);

        col_d = col_q;
        if (col_clr_i)      col_d = '0;
        else if (col_inc_i) col_d = col_q + CW'(1);

        k_d = '0;
        if (k_run_i && !k_last_o) k_d = k_q + KW'(1);

        addr_d = (ADDR_W'(row_d) + ADDR_W'(k_d)) * ADDR_W'(IMG_WIDTH) + ADDR_W'(col_d);
    end

    // Counter and address registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_q  <= '0;
            col_q  <= '0;
            k_q    <= '0;
            addr_q <= '0;
        end else begin
            row_q  <= row_d;
            col_q  <= col_d;
            k_q    <= k_d;
            addr_q <= addr_d;
        end
    end

endmodule

// File: rtl/cfa_window_seq.sv
// Window sequencer: scans the frame one FILTER_SIZE-row strip at a time,
// reads each column top to bottom into the line buffer and presents every
// complete window downstream. Optional build macro CFA_WIN_SEQ_STALL_CNT_EN
// adds a saturating 16-bit count of backpressure cycles (stall_cnt).
//
// Handshake: win_valid rises only in EMIT and holds win_row/win_col stable
// until a cycle where win_valid && win_ready; that cycle is the transfer.
module cfa_window_seq
    import cfa_pkg::*;
#(
    parameter int FILTER_SIZE = CFA_FILTER_SIZE,
    parameter int IMG_WIDTH   = 64,
    parameter int IMG_HEIGHT  = 64,
    parameter int RD_LAT      = CFA_RD_LAT,
    parameter int ADDR_W      = 12
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic                          mem_rd_en,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic                          buf_en,
    output logic                          buf_clr,
    output logic                          win_valid,
    input  logic                          win_ready,
`ifdef CFA_WIN_SEQ_STALL_CNT_EN
    output logic [15:0]                   stall_cnt,
`endif
    output logic [clog2(IMG_HEIGHT)-1:0]  win_row,
    output logic [clog2(IMG_WIDTH)-1:0]   win_col,
    output logic [2:0]                    dbg_state
);

    localparam logic [2:0] S_IDLE  = IDLE;
    localparam logic [2:0] S_CLEAR = CLEAR;
    localparam logic [2:0] S_FETCH = FETCH;
    localparam logic [2:0] S_WAIT  = WAIT;
    localparam logic [2:0] S_EMIT  = EMIT;
    localparam logic [2:0] S_DONE  = DONE;

    localparam int LW = clog2(FILTER_SIZE + 1);
    localparam int WW = clog2(RD_LAT + 1);

    logic [2:0]        state_q, state_d;
    logic [LW-1:0]     loaded_q, loaded_d, loaded_inc;
    logic [WW-1:0]     wait_q, wait_d;
    logic [RD_LAT-1:0] rd_pipe_q, rd_pipe_d;
    logic              row_clr, row_inc, col_clr, col_inc;
    logic              k_last, col_last, row_last;

    cfa_win_seq_addr_gen #(
        .FILTER_SIZE (FILTER_SIZE),
        .IMG_WIDTH   (IMG_WIDTH),
        .IMG_HEIGHT  (IMG_HEIGHT),
        .ADDR_W      (ADDR_W)
    ) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .row_clr_i  (row_clr),
        .row_inc_i  (row_inc),
        .col_clr_i  (col_clr),
        .col_inc_i  (col_inc),
        .k_run_i    (state_q == S_FETCH),
        .row_o      (win_row),
        .col_o      (win_col),
        .k_last_o   (k_last),
        .col_last_o (col_last),
        .row_last_o (row_last),
        .mem_addr_o (mem_addr)
    );

    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign mem_rd_en  = (state_q == S_FETCH);
    assign win_valid  = (state_q == S_EMIT);
    assign buf_clr    = rst | (state_q == S_CLEAR);
    assign buf_en     = rd_pipe_q[RD_LAT-1];
    assign dbg_state  = state_q;
    assign loaded_inc = (loaded_q == LW'(FILTER_SIZE)) ? loaded_q : loaded_q + LW'(1);

    // Next state and counter strobes for the strip/column scan.
    always_comb begin
        state_d  = state_q;
        loaded_d = loaded_q;
        wait_d   = '0;
        row_clr  = 1'b0;
        row_inc  = 1'b0;
        col_clr  = 1'b0;
        col_inc  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    row_clr = 1'b1;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                col_clr  = 1'b1;
                loaded_d = '0;
                state_d  = S_FETCH;
            end
            S_FETCH: begin
                if (k_last) state_d = S_WAIT;
            end
            S_WAIT: begin
                // Hold until the last read of the column has been written.
                if (wait_q == WW'(RD_LAT - 1)) begin
                    loaded_d = loaded_inc;
                    if (loaded_inc == LW'(FILTER_SIZE)) begin
                        state_d = S_EMIT;
                    end else begin
                        col_inc = 1'b1;
                        state_d = S_FETCH;
                    end
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            S_EMIT: begin
                if (win_ready) begin
                    if (!col_last) begin
                        col_inc = 1'b1;
                        state_d = S_FETCH;
                    end else if (!row_last) begin
                        row_inc = 1'b1;
                        state_d = S_CLEAR;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Delay line that turns each read strobe into the buffer write enable.
    always_comb begin
        rd_pipe_d    = rd_pipe_q;
        rd_pipe_d[0] = mem_rd_en;
        for (int i = 1; i < RD_LAT; i++) rd_pipe_d[i] = rd_pipe_q[i-1];
    end

    // FSM, fill-level, wait and read-pipe registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            loaded_q  <= '0;
            wait_q    <= '0;
            rd_pipe_q <= '0;
        end else begin
            state_q   <= state_d;
            loaded_q  <= loaded_d;
            wait_q    <= wait_d;
            rd_pipe_q <= rd_pipe_d;
        end
    end

`ifdef CFA_WIN_SEQ_STALL_CNT_EN
    logic [15:0] stall_q;
    assign stall_cnt = stall_q;

    // Saturating count of cycles a presented window waits for the consumer.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if (state_q == S_IDLE && start) begin
            stall_q <= '0;
        end else if (win_valid && !win_ready && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cfa_window_seq.sv
// Directed bench for cfa_window_seq (FILTER_SIZE=3, 8x6 frame) plus a
// second instance with RD_LAT=3 for read-to-write delay checks.
module tb_cfa_window_seq;

    localparam int F  = 3;
    localparam int W  = 8;
    localparam int H  = 6;
    localparam int AW = 12;

    // Clock and shared reset.
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, win_ready, start3;
    logic          busy, done, mem_rd_en, buf_en, buf_clr, win_valid;
    logic [AW-1:0] mem_addr;
    logic [2:0]    win_row, win_col, dbg_state;
    logic          busy3, done3, mem_rd_en3, buf_en3, buf_clr3, win_valid3;
    logic [AW-1:0] mem_addr3;
    logic [2:0]    win_row3, win_col3, dbg_state3;
`ifdef CFA_WIN_SEQ_STALL_CNT_EN
    logic [15:0]   stall_cnt, stall_cnt3;
`endif

    cfa_window_seq #(.FILTER_SIZE(F), .IMG_WIDTH(W), .IMG_HEIGHT(H), .RD_LAT(1), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .buf_en(buf_en), .buf_clr(buf_clr),
        .win_valid(win_valid), .win_ready(win_ready),
`ifdef CFA_WIN_SEQ_STALL_CNT_EN
        .stall_cnt(stall_cnt),
`endif
        .win_row(win_row), .win_col(win_col), .dbg_state(dbg_state)
    );

    cfa_window_seq #(.FILTER_SIZE(F), .IMG_WIDTH(W), .IMG_HEIGHT(H), .RD_LAT(3), .ADDR_W(AW)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .busy(busy3), .done(done3),
        .mem_rd_en(mem_rd_en3), .mem_addr(mem_addr3), .buf_en(buf_en3), .buf_clr(buf_clr3),
        .win_valid(win_valid3), .win_ready(1'b1),
`ifdef CFA_WIN_SEQ_STALL_CNT_EN
        .stall_cnt(stall_cnt3),
`endif
        .win_row(win_row3), .win_col(win_col3), .dbg_state(dbg_state3)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Scoreboard of expected read addresses, consumed in issue order.
    logic [AW-1:0] exp_q[$];
    logic          addr_chk_en = 1'b0;

    int rd_cnt, acc_cnt, done_cnt, buf_cnt;
    logic          strip_en = 1'b0, strip_armed = 1'b0, strip_seen = 1'b0;
    int            strip_clr;
    logic [AW-1:0] strip_addr;

    logic       mon3_en = 1'b0;
    logic [2:0] hist3 = 3'b000;
    int cyc = 0, lag_bad = 0, first_rd3 = -1, first_buf3 = -1;
    int rd3_cnt = 0, done3_cnt = 0, clr3_cnt = 0;
    logic [AW-1:0] first_addr3 = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counters();
        rd_cnt   = 0;
        acc_cnt  = 0;
        done_cnt = 0;
        buf_cnt  = 0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        check("frame_end", busy, 0);
    endtask

    // Monitor for the RD_LAT=1 instance, sampled mid-cycle.
    always @(negedge clk) begin
        logic [AW-1:0] e;
        if (mem_rd_en) rd_cnt++;
        if (win_valid && win_ready) acc_cnt++;
        if (done) done_cnt++;
        if (buf_en) buf_cnt++;
        if (addr_chk_en && mem_rd_en && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("rd_addr", mem_addr, e);
        end
        if (strip_armed) begin
            if (buf_clr) strip_clr++;
            if (mem_rd_en) begin
                strip_addr  = mem_addr;
                strip_armed = 1'b0;
                strip_seen  = 1'b1;
            end
        end
        if (strip_en && win_valid && win_ready && win_row == 3'd0 && win_col == 3'd7) begin
            strip_armed = 1'b1;
            strip_clr   = 0;
            strip_en    = 1'b0;
        end
    end

    // Monitor for the RD_LAT=3 instance.
    always @(negedge clk) begin
        cyc++;
        if (mon3_en) begin
            if (buf_en3 !== hist3[2]) lag_bad++;
            if (mem_rd_en3) begin
                if (first_rd3 < 0) begin
                    first_rd3   = cyc;
                    first_addr3 = mem_addr3;
                end
                rd3_cnt++;
            end
            if (buf_en3 && first_buf3 < 0) first_buf3 = cyc;
            if (done3) done3_cnt++;
            if (buf_clr3) clr3_cnt++;
        end
        hist3 = {hist3[1:0], mem_rd_en3};
    end

    initial begin
        int lat, n, frz_bad;
        logic [2:0]    s_row, s_col;
        logic [AW-1:0] s_addr;
        int a1[9] = '{0, 8, 16, 1, 9, 17, 2, 10, 18};

        // Reset values.
        rst = 1'b1; start = 1'b0; start3 = 1'b0; win_ready = 1'b1;
        clear_counters();
        tick(); tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd_en", mem_rd_en, 0);
        check("rst_buf_en", buf_en, 0);
        check("rst_win_valid", win_valid, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_win_row", win_row, 0);
        check("rst_win_col", win_col, 0);
        check("rst_buf_clr", buf_clr, 1);
        check("rst_state", dbg_state, 0);
        rst = 1'b0;
        tick();
        check("idle_buf_clr", buf_clr, 0);

        // Frame 1: free-running consumer, address order, strip boundary.
        clear_counters();
        foreach (a1[i]) exp_q.push_back(AW'(a1[i]));
        addr_chk_en = 1'b1;
        strip_en    = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        lat = 0;
        while (!win_valid && lat < 200) begin tick(); lat++; end
        // Counted to the first edge that samples win_valid high.
        check("first_win_latency", lat + 1, 14);
        check("first_win_row", win_row, 0);
        check("first_win_col", win_col, 2);
        wait_idle(2000);
        tick();
        check("f1_accepts", acc_cnt, 24);
        check("f1_reads", rd_cnt, 96);
        check("f1_done_pulses", done_cnt, 1);
        check("f1_addr_queue_left", exp_q.size(), 0);
        check("strip_seen", strip_seen, 1);
        check("strip_buf_clr", strip_clr, 1);
        check("strip_next_addr", strip_addr, 8);
        check("f1_end_state", dbg_state, 0);
        addr_chk_en = 1'b0;

        // Frame 2: backpressure on the third window.
        clear_counters();
        start = 1'b1; tick(); start = 1'b0;
        n = 0;
        while (!(win_valid && acc_cnt == 2) && n < 500) begin tick(); n++; end
        check("bp_valid", win_valid, 1);
        win_ready = 1'b0;
        s_row = win_row; s_col = win_col; s_addr = mem_addr;
        buf_cnt = 0; frz_bad = 0;
        check("bp_win_row", s_row, 0);
        check("bp_win_col", s_col, 4);
        check("bp_addr", s_addr, 4);
        repeat (20) begin
            tick();
            if (win_valid !== 1'b1 || win_row !== s_row || win_col !== s_col || mem_addr !== s_addr)
                frz_bad++;
        end
        check("bp_frozen", frz_bad, 0);
        check("bp_no_buf_en", buf_cnt, 0);
        check("bp_accepts_held", acc_cnt, 2);
`ifdef CFA_WIN_SEQ_STALL_CNT_EN
        check("bp_stall_cnt", stall_cnt, 20);
`endif
        win_ready = 1'b1;
        wait_idle(2000);
        tick();
        check("bp_accepts_total", acc_cnt, 24);
        check("bp_done_pulses", done_cnt, 1);

        // Frame 3: reset during the second strip, then replay.
        clear_counters();
        start = 1'b1; tick(); start = 1'b0;
        n = 0;
        while (!(mem_rd_en && win_row == 3'd1) && n < 500) begin tick(); n++; end
        check("mid_fetch_reached", mem_rd_en, 1);
        rst = 1'b1;
        tick();
        check("mid_rst_busy", busy, 0);
        check("mid_rst_rd_en", mem_rd_en, 0);
        check("mid_rst_buf_en", buf_en, 0);
        check("mid_rst_addr", mem_addr, 0);
        check("mid_rst_state", dbg_state, 0);
        rst = 1'b0;
        tick();
        clear_counters();
        exp_q.push_back(AW'(0)); exp_q.push_back(AW'(8)); exp_q.push_back(AW'(16));
        addr_chk_en = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        wait_idle(2000);
        tick();
        check("replay_accepts", acc_cnt, 24);
        check("replay_reads", rd_cnt, 96);
        check("replay_addr_queue_left", exp_q.size(), 0);
        addr_chk_en = 1'b0;

        // RD_LAT=3 instance.
        mon3_en = 1'b1;
        start3 = 1'b1; tick(); start3 = 1'b0;
        lat = 0;
        while (!win_valid3 && lat < 200) begin tick(); lat++; end
        check("lat3_first_win_latency", lat + 1, 20);
        check("lat3_win_row", win_row3, 0);
        check("lat3_win_col", win_col3, 2);
        n = 0;
        while (busy3 && n < 3000) begin tick(); n++; end
        check("lat3_frame_end", busy3, 0);
        tick();
        mon3_en = 1'b0;
        check("lat3_buf_en_lag", lag_bad, 0);
        check("lat3_first_gap", first_buf3 - first_rd3, 3);
        check("lat3_first_addr", first_addr3, 0);
        check("lat3_reads", rd3_cnt, 96);
        check("lat3_done_pulses", done3_cnt, 1);
        check("lat3_strip_clears", clr3_cnt, 4);
        check("lat3_end_state", dbg_state3, 0);
`ifdef CFA_WIN_SEQ_STALL_CNT_EN
        check("lat3_stall_cnt", stall_cnt3, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
